nios_core_pio_in: RTL and testbench

//   Avalon-MM slave input port (s1): the read-side counterpart of the LED output PIOs.

---
 rtl/nios_core_pio_in.sv | 181 ++++++++++++++++++
 tb/tb_nios_core_pio_in.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nios_core_pio_in.sv
// Avalon-MM input PIO: synchronizer, optional per-bit debounce,
// sticky edge capture with W1C clear, and a maskable level IRQ.
module nios_core_pio_in #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      DEBOUNCE   = 0,
  parameter int unsigned      EDGE_TYPE  = 2,
  parameter logic [WIDTH-1:0] IDLE_LEVEL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CW =
    (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_DIR  = 2'd1;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_EDGE = 2'd3;

  // register state
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ecap_q, ecap_d;
  logic [31:0]      rdata_q, rdata_d;

  // combinational helpers
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] clr;
  logic             wr_en;
  logic             mask_we;
  logic             clr_we;

  assign wdata = writedata[WIDTH-1:0];

  // bus write decode; address 0 and 1 are read-only
  always_comb begin
    wr_en   = chipselect & ~write_n;
    mask_we = 1'b0;
    clr_we  = 1'b0;
    if (wr_en) begin
      unique case (address)
        A_MASK:  mask_we = 1'b1;
        A_EDGE:  clr_we  = 1'b1;
        A_DATA,
        A_DIR:   ;
        default: ;
      endcase
    end
  end

  // two-stage synchronizer for the asynchronous pins
  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
  end

  // synchronizer flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  if (DEBOUNCE == 0) begin : g_nodb

    assign filt = sync2_q;

  end else begin : g_db

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [WIDTH-1:0] filt_q, filt_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // per-bit stability counter; accept a change only
    // after DEBOUNCE consecutive mismatching samples
    always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_d[i] = cnt_q[i];
        if (sync2_q[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    // filter state; reset drops any pending change
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        filt_q <= IDLE_LEVEL;
        for (int i = 0; i < int'(WIDTH); i++) begin
          cnt_q[i] <= '0;
        end
      end else begin
        filt_q <= filt_d;
        for (int i = 0; i < int'(WIDTH); i++) begin
          cnt_q[i] <= cnt_d[i];
        end
      end
    end

    assign filt = filt_q;

  end

  // edge detection against last cycle's filtered value
  always_comb begin
    prev_d = filt;
    rise   = filt & ~prev_q;
    fall   = ~filt & prev_q;
    if (EDGE_TYPE == 0) begin
      sel = rise;
    end else if (EDGE_TYPE == 1) begin
      sel = fall;
    end else begin
      sel = rise | fall;
    end
  end

  // sticky capture; a new edge beats a same-cycle clear
  always_comb begin
    clr    = clr_we ? wdata : '0;
    ecap_d = (ecap_q & ~clr) | sel;
    mask_d = mask_we ? wdata : mask_q;
  end

  // read mux, sampled every edge, no read side effects
  always_comb begin
    rdata_d = '0;
    unique case (address)
      A_DATA:  rdata_d[WIDTH-1:0] = filt;
      A_DIR:   rdata_d = '0;
      A_MASK:  rdata_d[WIDTH-1:0] = mask_q;
      A_EDGE:  rdata_d[WIDTH-1:0] = ecap_q;
      default: rdata_d = '0;
    endcase
  end

  // control and read-data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= IDLE_LEVEL;
      mask_q  <= '0;
      ecap_q  <= '0;
      rdata_q <= '0;
    end else begin
      prev_q  <= prev_d;
      mask_q  <= mask_d;
      ecap_q  <= ecap_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = |(ecap_q & mask_q);

endmodule

// File: tb/tb_nios_core_pio_in.sv
// Bench for nios_core_pio_in: four instances cover default,
// debounced, rising-only and falling-only configurations.
module tb_nios_core_pio_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_a, in_db, in_ef;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic        irq0, irq1, irq2, irq3;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    int          which;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t sb [$];

  always #5 clk = ~clk;

  nios_core_pio_in #(.WIDTH(8), .DEBOUNCE(0), .EDGE_TYPE(2))
  u_any (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_a),
    .readdata(rd0), .irq(irq0)
  );

  nios_core_pio_in #(.WIDTH(8), .DEBOUNCE(4), .EDGE_TYPE(2))
  u_db (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_db),
    .readdata(rd1), .irq(irq1)
  );

  nios_core_pio_in #(.WIDTH(8), .DEBOUNCE(0), .EDGE_TYPE(0))
  u_rise (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_ef),
    .readdata(rd2), .irq(irq2)
  );

  nios_core_pio_in #(.WIDTH(8), .DEBOUNCE(0), .EDGE_TYPE(1))
  u_fall (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_ef),
    .readdata(rd3), .irq(irq3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick_rd(input int w);
    case (w)
      0:       return rd0;
      1:       return rd1;
      2:       return rd2;
      default: return rd3;
    endcase
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a,
                           input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input string tag, input int w,
                          input logic [1:0] a,
                          input logic [31:0] exp);
    rd_exp_t e;
    e.tag   = tag;
    e.which = w;
    e.exp   = exp;
    sb.push_back(e);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    @(negedge clk);
    chipselect = 1'b0;
    e = sb.pop_front();
    chk(e.tag, pick_rd(e.which), e.exp);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_a       = 8'hA5;
    in_db      = 8'h00;
    in_ef      = 8'h00;

    // reset state
    tick(3);
    chk("rst_rd", rd0, 32'h0);
    chk("rst_irq", {31'b0, irq0}, 32'h0);
    reset_n = 1'b1;
    tick(2);
    bus_read("rst_filt", 0, 2'd0, 32'hA5);
    bus_read("rst_ecap", 0, 2'd3, 32'hA5);
    chk("rst_irq_mask0", {31'b0, irq0}, 32'h0);
    in_a = 8'h00;
    tick(4);
    bus_write(2'd3, 32'hFF);
    bus_read("clr_all", 0, 2'd3, 32'h0);

    // capture and irq
    bus_write(2'd2, 32'h01);
    bus_read("mask_rd", 0, 2'd2, 32'h01);
    in_a = 8'h01;
    tick(2);
    chk("cap_irq_e2", {31'b0, irq0}, 32'h0);
    tick(1);
    chk("cap_irq_e3", {31'b0, irq0}, 32'h1);
    bus_read("cap_ecap", 0, 2'd3, 32'h01);
    bus_write(2'd3, 32'h01);
    chk("w1c_irq", {31'b0, irq0}, 32'h0);
    bus_read("w1c_ecap", 0, 2'd3, 32'h0);
    bus_read("dir_rd", 0, 2'd1, 32'h0);

    // masking
    bus_write(2'd2, 32'h00);
    in_a = 8'h09;
    tick(4);
    chk("mask_irq0", {31'b0, irq0}, 32'h0);
    bus_read("mask_ecap", 0, 2'd3, 32'h08);
    bus_write(2'd2, 32'h08);
    chk("mask_irq1", {31'b0, irq0}, 32'h1);
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'h00);
    chk("mask_irq_off", {31'b0, irq0}, 32'h0);

    // debounce: short glitch rejected
    in_db = 8'h02;
    tick(3);
    in_db = 8'h00;
    tick(10);
    bus_read("db_glitch_filt", 1, 2'd0, 32'h0);
    bus_read("db_glitch_ecap", 1, 2'd3, 32'h0);
    // debounce: clean level flips filt at edge 6
    in_db = 8'h02;
    tick(5);
    bus_read("db_e6_old", 1, 2'd0, 32'h0);
    bus_read("db_e7_new", 1, 2'd0, 32'h02);
    bus_read("db_ecap", 1, 2'd3, 32'h02);

    // race: set beats same-cycle clear
    in_a = 8'h0D;
    tick(2);
    bus_write(2'd3, 32'h04);
    bus_read("race_ecap", 0, 2'd3, 32'h04);
    // read in same cycle as a set returns the old value
    in_a = 8'h1D;
    tick(2);
    bus_read("race_rd_old", 0, 2'd3, 32'h04);
    bus_read("race_rd_new", 0, 2'd3, 32'h14);

    // edge type
    bus_write(2'd3, 32'hFF);
    in_ef = 8'hFF;
    tick(4);
    bus_read("rise_on_rise", 2, 2'd3, 32'hFF);
    bus_read("fall_on_rise", 3, 2'd3, 32'h00);
    bus_write(2'd3, 32'hFF);
    in_ef = 8'h00;
    tick(4);
    bus_read("rise_on_fall", 2, 2'd3, 32'h00);
    bus_read("fall_on_fall", 3, 2'd3, 32'hFF);

    // async reset clears state mid-run
    bus_write(2'd2, 32'hFF);
    chk("pre_rst_irq", {31'b0, irq3}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("arst_irq", {31'b0, irq3}, 32'h0);
    chk("arst_rd", rd3, 32'h0);
    tick(1);
    reset_n = 1'b1;
    tick(1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
